// File: rtl/plm_bank_arbiter_if.sv
// Consumer/PLM bus bundle for plm_bank_arbiter; slave = arbiter side, master = consumers and PLM.
// No timing of its own: carries valid/ready requests, registered port commands and read responses.
interface plm_bank_arbiter_if #(
   parameter int ADDR_WIDTH  = 4,
   parameter int VALUE_WIDTH = 8,
   parameter int NCONSUMERS  = 2,
   parameter int NBANKS      = 1,
   parameter int NPORTS      = 2
);
   localparam int BANK_BITS       = $clog2(NBANKS);
   localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;
   localparam int PLM_INPUT_WIDTH = BANK_ADDR_WIDTH + VALUE_WIDTH + 1;
   localparam int NKERNELS        = NBANKS * NPORTS;

   logic                       req_valid [NCONSUMERS];
   logic                       req_we    [NCONSUMERS];
   logic [ADDR_WIDTH-1:0]      req_addr  [NCONSUMERS];
   logic [VALUE_WIDTH-1:0]     req_value [NCONSUMERS];
   logic                       req_ready [NCONSUMERS];
   logic                       plm_valid [NKERNELS];
   logic [PLM_INPUT_WIDTH-1:0] plm_out   [NKERNELS];
   logic [VALUE_WIDTH-1:0]     plm_rdata [NKERNELS];
   logic                       rsp_valid [NCONSUMERS];
   logic [VALUE_WIDTH-1:0]     rsp_data  [NCONSUMERS];

   modport master (
      output req_valid, req_we, req_addr, req_value, plm_rdata,
      input  req_ready, plm_valid, plm_out, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_value, plm_rdata,
      output req_ready, plm_valid, plm_out, rsp_valid, rsp_data
   );
endinterface

// File: rtl/plm_bank_arbiter.sv
// Round-robin arbiter of NCONSUMERS requesters onto NBANKS x NPORTS PLM ports; command one cycle after accept,
// read response two cycles after accept. Excess requesters on a bank see req_ready low until their turn.
module plm_bank_arbiter #(
   parameter int ADDR_WIDTH  = 4,
   parameter int VALUE_WIDTH = 8,
   parameter int NCONSUMERS  = 2,
   parameter int NBANKS      = 1,
   parameter int NPORTS      = 2
) (
   input  logic            clk,
   input  logic            reset,
   plm_bank_arbiter_if.slave bus
);
   localparam int BANK_BITS       = $clog2(NBANKS);
   localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - BANK_BITS;
   localparam int PLM_INPUT_WIDTH = BANK_ADDR_WIDTH + VALUE_WIDTH + 1;
   localparam int NKERNELS        = NBANKS * NPORTS;
   localparam int CW              = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

   typedef struct packed {
      logic          pend;
      logic [CW-1:0] cons;
   } tag_t;

   logic [CW-1:0]              ptr_q     [NBANKS];
   logic [CW-1:0]              ptr_d     [NBANKS];
   logic                       plm_vld_q [NKERNELS];
   logic                       plm_vld_d [NKERNELS];
   logic [PLM_INPUT_WIDTH-1:0] plm_out_q [NKERNELS];
   logic [PLM_INPUT_WIDTH-1:0] plm_out_d [NKERNELS];
   tag_t                       tag1_q    [NKERNELS];
   tag_t                       tag1_d    [NKERNELS];
   tag_t                       tag2_q    [NKERNELS];
   tag_t                       tag2_d    [NKERNELS];
   logic                       grant     [NCONSUMERS];

   always_comb begin : arbitrate
      int cnt;
      int idx;
      int k;
      cnt = 0;
      idx = 0;
      k   = 0;
      for (int c = 0; c < NCONSUMERS; c++) grant[c] = 1'b0;
      for (int kk = 0; kk < NKERNELS; kk++) begin
         plm_vld_d[kk] = 1'b0;
         plm_out_d[kk] = plm_out_q[kk];
         tag1_d[kk]    = '0;
         tag2_d[kk]    = tag1_q[kk];
      end
      for (int b = 0; b < NBANKS; b++) begin
         ptr_d[b] = ptr_q[b];
         cnt      = 0;
         // Scan from the bank pointer; ports are handed out in scan order.
         for (int i = 0; i < NCONSUMERS; i++) begin
            idx = int'(ptr_q[b]) + i;
            if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
            if (!reset && bus.req_valid[idx] && cnt < NPORTS &&
                int'(bus.req_addr[idx] & ADDR_WIDTH'(NBANKS - 1)) == b) begin
               k             = b * NPORTS + cnt;
               grant[idx]    = 1'b1;
               plm_vld_d[k]  = 1'b1;
               plm_out_d[k]  = {bus.req_we[idx],
                                BANK_ADDR_WIDTH'(bus.req_addr[idx] >> BANK_BITS),
                                bus.req_value[idx]};
               tag1_d[k].pend = !bus.req_we[idx];
               tag1_d[k].cons = CW'(idx);
               ptr_d[b]      = (idx == NCONSUMERS - 1) ? '0 : CW'(idx + 1);
               cnt           = cnt + 1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NBANKS; b++) ptr_q[b] <= '0;
         for (int k = 0; k < NKERNELS; k++) begin
            plm_vld_q[k] <= 1'b0;
            plm_out_q[k] <= '0;
            tag1_q[k]    <= '0;
            tag2_q[k]    <= '0;
         end
      end else begin
         ptr_q     <= ptr_d;
         plm_vld_q <= plm_vld_d;
         plm_out_q <= plm_out_d;
         tag1_q    <= tag1_d;
         tag2_q    <= tag2_d;
      end
   end

   // Responses are combinational from the PLM read data, steered by the aligned tag.
   always_comb begin
      for (int c = 0; c < NCONSUMERS; c++) begin
         bus.rsp_valid[c] = 1'b0;
         bus.rsp_data[c]  = '0;
      end
      for (int k = 0; k < NKERNELS; k++) begin
         if (tag2_q[k].pend) begin
            bus.rsp_valid[tag2_q[k].cons] = 1'b1;
            bus.rsp_data[tag2_q[k].cons]  = bus.plm_rdata[k];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NCONSUMERS; c++) bus.req_ready[c] = grant[c];
      for (int k = 0; k < NKERNELS; k++) begin
         bus.plm_valid[k] = plm_vld_q[k];
         bus.plm_out[k]   = plm_out_q[k];
      end
   end
endmodule

// File: tb/tb_plm_bank_arbiter.sv
// Bench for plm_bank_arbiter with 4 consumers, 2 banks, 2 ports per bank, driving a small PLM memory model.
module tb_plm_bank_arbiter;
   localparam int AW  = 4;
   localparam int VW  = 8;
   localparam int NC  = 4;
   localparam int NB  = 2;
   localparam int NP  = 2;
   localparam int BAW = AW - $clog2(NB);
   localparam int PIW = BAW + VW + 1;
   localparam int NK  = NB * NP;
   localparam int DEPTH = 1 << BAW;

   typedef struct packed { int stamp; logic [NC-1:0] rdy; } rdy_exp_t;
   typedef struct packed { int stamp; logic [NK-1:0] pv; logic [NK-1:0][PIW-1:0] po; } plm_exp_t;
   typedef struct packed { int stamp; int cons; logic [VW-1:0] data; } rsp_exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   plm_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                         .NBANKS(NB), .NPORTS(NP)) bus ();

   plm_bank_arbiter #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                      .NBANKS(NB), .NPORTS(NP)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   int             m_ptr [NB];
   logic [PIW-1:0] m_out [NK];
   logic [VW-1:0]  m_mem [NB][DEPTH];
   rdy_exp_t       rdy_q [$];
   plm_exp_t       plm_q [$];
   rsp_exp_t       rsp_q [$];

   // Stimulus state
   logic [NC-1:0]  d_valid, d_we, last_grant;
   logic [AW-1:0]  d_addr [NC];
   logic [VW-1:0]  d_val  [NC];

   // PLM bank model: read data appears the cycle after the command, reads see pre-write contents.
   logic [VW-1:0]  plm_mem [NB][DEPTH];
   always @(posedge clk) begin
      for (int k = 0; k < NK; k++) begin
         if (bus.plm_valid[k] === 1'b1 && bus.plm_out[k][PIW-1] == 1'b0)
            bus.plm_rdata[k] <= plm_mem[k / NP][bus.plm_out[k][PIW-2:VW]];
         else
            bus.plm_rdata[k] <= VW'($urandom);
      end
      for (int k = 0; k < NK; k++)
         if (bus.plm_valid[k] === 1'b1 && bus.plm_out[k][PIW-1] == 1'b1)
            plm_mem[k / NP][bus.plm_out[k][PIW-2:VW]] <= bus.plm_out[k][VW-1:0];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic set_req(input int c, input bit v, input bit we, input int addr, input int val);
      d_valid[c] = v;
      d_we[c]    = we;
      d_addr[c]  = AW'(addr);
      d_val[c]   = VW'(val);
   endtask

   task automatic idle();
      d_valid = '0;
   endtask

   // Drive one cycle, predict its outcome from the arbitration rules, then advance.
   task automatic step(input bit rst);
      int             n, c, a, k, take;
      int             q [$];
      logic [NC-1:0]  g;
      logic [NK-1:0]  wr_en;
      logic [BAW-1:0] wr_a [NK];
      logic [VW-1:0]  wr_d [NK];
      plm_exp_t       pe;
      rdy_exp_t       re;
      rsp_exp_t       rs;
      n = cyc;
      g = '0;
      wr_en = '0;
      pe.pv = '0;
      reset = rst;
      for (int i = 0; i < NC; i++) begin
         bus.req_valid[i] = d_valid[i];
         bus.req_we[i]    = d_we[i];
         bus.req_addr[i]  = d_addr[i];
         bus.req_value[i] = d_val[i];
      end
      if (rst) begin
         for (int b = 0; b < NB; b++) m_ptr[b] = 0;
         for (int i = 0; i < NK; i++) m_out[i] = '0;
         while (rsp_q.size() > 0 && rsp_q[$].stamp > n) rs = rsp_q.pop_back();
      end else begin
         for (int b = 0; b < NB; b++) begin
            q.delete();
            for (int i = 0; i < NC; i++) begin
               c = (m_ptr[b] + i) % NC;
               if (d_valid[c] && int'(d_addr[c]) % NB == b) q.push_back(c);
            end
            take = (q.size() < NP) ? q.size() : NP;
            for (int p = 0; p < take; p++) begin
               c = q[p];
               a = int'(d_addr[c]) / NB;
               k = b * NP + p;
               g[c] = 1'b1;
               pe.pv[k] = 1'b1;
               m_out[k] = {d_we[c], BAW'(a), d_val[c]};
               if (d_we[c]) begin
                  wr_en[k] = 1'b1;
                  wr_a[k]  = BAW'(a);
                  wr_d[k]  = d_val[c];
               end else begin
                  rs.stamp = n + 2;
                  rs.cons  = c;
                  rs.data  = m_mem[b][a];
                  rsp_q.push_back(rs);
               end
            end
            if (take > 0) m_ptr[b] = (q[take-1] + 1) % NC;
         end
         for (int i = 0; i < NK; i++)
            if (wr_en[i]) m_mem[i / NP][wr_a[i]] = wr_d[i];
      end
      for (int i = 0; i < NK; i++) pe.po[i] = m_out[i];
      pe.stamp = n + 1;
      re.stamp = n;
      re.rdy   = g;
      rdy_q.push_back(re);
      plm_q.push_back(pe);
      last_grant = g;
      @(posedge clk);
      #1;
   endtask

   // Monitor: consumes whatever expectations fall due in the current cycle.
   rdy_exp_t      mr;
   plm_exp_t      mp;
   rsp_exp_t      ms;
   logic [NC-1:0] ev;
   logic [VW-1:0] ed [NC];
   always @(negedge clk) begin
      if (rdy_q.size() > 0 && rdy_q[0].stamp == cyc) begin
         mr = rdy_q.pop_front();
         for (int c = 0; c < NC; c++) chk($sformatf("req_ready[%0d]", c), 64'(bus.req_ready[c]), 64'(mr.rdy[c]));
      end
      if (plm_q.size() > 0 && plm_q[0].stamp == cyc) begin
         mp = plm_q.pop_front();
         for (int k = 0; k < NK; k++) begin
            chk($sformatf("plm_valid[%0d]", k), 64'(bus.plm_valid[k]), 64'(mp.pv[k]));
            chk($sformatf("plm_out[%0d]", k), 64'(bus.plm_out[k]), 64'(mp.po[k]));
         end
      end
      if (cyc >= 1) begin
         ev = '0;
         for (int c = 0; c < NC; c++) ed[c] = '0;
         while (rsp_q.size() > 0 && rsp_q[0].stamp <= cyc) begin
            ms = rsp_q.pop_front();
            if (ms.stamp != cyc) chk("rsp_stamp", 64'(cyc), 64'(ms.stamp));
            else begin
               ev[ms.cons] = 1'b1;
               ed[ms.cons] = ms.data;
            end
         end
         for (int c = 0; c < NC; c++) begin
            chk($sformatf("rsp_valid[%0d]", c), 64'(bus.rsp_valid[c]), 64'(ev[c]));
            if (ev[c]) chk($sformatf("rsp_data[%0d]", c), 64'(bus.rsp_data[c]), 64'(ed[c]));
         end
      end
   end

   initial begin
      reset = 1'b1;
      d_valid = '0;
      d_we = '0;
      last_grant = '0;
      for (int c = 0; c < NC; c++) begin
         d_addr[c] = '0;
         d_val[c]  = '0;
         bus.req_valid[c] = 1'b0;
         bus.req_we[c]    = 1'b0;
         bus.req_addr[c]  = '0;
         bus.req_value[c] = '0;
      end
      for (int b = 0; b < NB; b++) begin
         m_ptr[b] = 0;
         for (int a = 0; a < DEPTH; a++) begin
            m_mem[b][a]   = VW'(8'h30 + b * 16 + a);
            plm_mem[b][a] = VW'(8'h30 + b * 16 + a);
         end
      end
      for (int k = 0; k < NK; k++) m_out[k] = '0;
      @(posedge clk);
      #1;

      // Reset held with every consumer requesting bank 0, then release.
      for (int c = 0; c < NC; c++) set_req(c, 1, 0, 2 * c, 0);
      step(1);
      step(1);
      step(0);
      idle();
      step(0);

      // Write then read the same location.
      set_req(0, 1, 1, 2, 8'hA5);
      step(0);
      set_req(0, 1, 0, 2, 0);
      step(0);
      idle();
      step(0);
      step(0);

      // Contention on bank 1, then a lone requester.
      for (int c = 0; c < NC; c++) set_req(c, 1, 0, 2 * c + 1, 0);
      repeat (4) step(0);
      idle();
      set_req(3, 1, 0, 7, 0);
      repeat (3) step(0);

      // Two banks in parallel, same bank address.
      idle();
      set_req(0, 1, 0, 4, 0);
      set_req(1, 1, 0, 5, 0);
      step(0);
      idle();
      step(0);
      step(0);

      // Reset while a read is in flight.
      set_req(0, 1, 0, 4, 0);
      step(0);
      idle();
      step(1);
      repeat (3) step(0);

      // Three requesters on bank 0; the loser drops its request.
      for (int c = 0; c < 3; c++) set_req(c, 1, 0, 2 * c, 0);
      step(0);
      d_valid[2] = 1'b0;
      step(0);
      idle();
      step(0);

      // Random traffic with occasional resets.
      for (int t = 0; t < 1500; t++) begin
         for (int c = 0; c < NC; c++) begin
            if (d_valid[c] && !last_grant[c]) begin
               if ($urandom_range(0, 7) == 0) d_valid[c] = 1'b0;
            end else begin
               d_valid[c] = ($urandom_range(0, 3) != 0);
               d_we[c]    = 1'($urandom_range(0, 1));
               d_addr[c]  = AW'($urandom);
               d_val[c]   = VW'($urandom);
            end
         end
         step($urandom_range(0, 99) == 0);
      end

      idle();
      repeat (4) step(0);
      @(negedge clk);
      #1;
      chk("rsp_drain", 64'(rsp_q.size()), 64'(0));
      chk("plm_drain", 64'(plm_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
